// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Start/busy/done handshake plus operand and result bus for the bit-serial
//   subtractor.
//
//   Signals:
//     start    controller -> subtractor  request, accepted only when busy=0
//     a, b     controller -> subtractor  minuend / subtrahend (WIDTH bits)
//     bw_in    controller -> subtractor  borrow-in
//     busy     subtractor -> controller  operation in progress
//     done     subtractor -> controller  one-cycle completion pulse
//     diff     subtractor -> controller  a - b - bw_in mod 2^WIDTH
//     bw_out   subtractor -> controller  final borrow
//     overflow subtractor -> controller  two's-complement overflow
//
//   Modports:
//     master  the lab controller side (drives the request)
//     slave   the subtractor side (drives the response)
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bw_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bw_out;
  logic             overflow;

  modport master (
    output start, a, b, bw_in,
    input  busy, done, diff, bw_out, overflow
  );

  modport slave (
    input  start, a, b, bw_in,
    output busy, done, diff, bw_out, overflow
  );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = a - b - bw_in, one bit per clock,
//   LSB first, through a single full-subtractor cell and a rippling borrow
//   flip-flop. Operands are captured into shift registers on an accepted
//   start; the result is assembled in an internal shift register and only
//   copied to the visible outputs on the completion edge, so no partial
//   result is ever presented.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_subtractor_if.slave
//              start/a/b/bw_in in, busy/done/diff/bw_out/overflow out
//
//   Timing: start sampled at edge E0 -> busy for WIDTH cycles -> done high
//   for exactly one cycle after edge E0+WIDTH. A start during the done cycle
//   is accepted (back-to-back); a start while busy is ignored.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_if.slave    bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_sa;        // minuend shift register
  logic [WIDTH-1:0] r_sb;        // subtrahend shift register
  logic [WIDTH-2:0] r_res;       // upper result bits assembled so far
  logic             r_br;        // rippling borrow
  logic             r_a_msb;     // operand sign bits kept for overflow
  logic             r_b_msb;
  logic [CW-1:0]    r_count;     // bit index being processed

  logic [WIDTH-1:0] r_diff;
  logic             r_bw_out;
  logic             r_overflow;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_res_shift;

  // A new request is taken in IDLE and also in DONE, which gives
  // back-to-back operation without a dead cycle.
  assign w_accept = bus.start && (r_state != S_RUN);

  // The edge that processes the final bit is the one where the counter
  // still reads WIDTH-1 (it was cleared to zero on the accept edge).
  assign w_last = (r_state == S_RUN) && (r_count == CW'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs.
  assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);

  // The new bit enters at the MSB; after WIDTH shifts bit 0 has arrived at
  // position 0, so on the last edge this vector is the completed result.
  assign w_res_shift = {w_d, r_res};

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_next_state = S_RUN;
        else          w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Serial datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sa    <= bus.a;
      r_sb    <= bus.b;
      r_res   <= '0;
      r_br    <= bus.bw_in;
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_res   <= w_res_shift[WIDTH-1:1];
      r_br    <= w_br_next;
      r_count <= r_count + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Visible results: updated only on the completion edge and held otherwise,
  // through IDLE and through the whole of any following run.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff     <= '0;
      r_bw_out   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_last) begin
      r_diff     <= w_res_shift;
      r_bw_out   <= w_br_next;
      // Signed overflow: operand signs differ and the result sign differs
      // from the minuend sign. The final bit processed is the result MSB.
      r_overflow <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.diff     = r_diff;
  assign bus.bw_out   = r_bw_out;
  assign bus.overflow = r_overflow;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor. An acceptance process pushes
//   the reference result for every accepted start into a queue; a monitor
//   pops and compares whenever done is presented. Directed sequences check
//   handshake timing, hold behaviour, ignored starts, back-to-back starts and
//   asynchronous reset; a random sweep covers both borrow-in values.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // {bw_out, overflow, diff}
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned arithmetic on a widened result; the
  // overflow flag is the signed-overflow rule on operand and result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic bw);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bw};
    ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    return {full[W], ovf, full[W-1:0]};
  endfunction

  // Acceptance: a start seen while not busy launches an operation.
  always @(posedge clk) begin
    if (rst_n && bus.start && !bus.busy)
      exp_q.push_back(model(bus.a, bus.b, bus.bw_in));
  end

  // Monitor: compare on every done pulse, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_and_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("done_without_request", 32'd1, 32'd0);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check("result", {22'd0, bus.bw_out, bus.overflow, bus.diff}, {22'd0, e});
        end
      end
    end
  end

  // Drive a request; caller decides when (at a negedge, or during done).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bw);
    bus.a     = a;
    bus.b     = b;
    bus.bw_in = bw;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Wait for done (bounded); returns at the negedge where done is seen.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] d,
                              input logic bo, input logic ov);
    check({name, "_diff"},     {24'd0, bus.diff}, {24'd0, d});
    check({name, "_bw_out"},   {31'd0, bus.bw_out}, {31'd0, bo});
    check({name, "_overflow"}, {31'd0, bus.overflow}, {31'd0, ov});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bw_in = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check_result("reset", 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 0x5A - 0x3C with full handshake timing.
    issue(8'h5A, 8'h3C, 1'b0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("run_busy", {31'd0, bus.busy}, 32'd1);
      check("run_done", {31'd0, bus.done}, 32'd0);
      check("run_diff_hidden", {24'd0, bus.diff}, 32'd0);
    end
    @(negedge clk);
    check("latency_done", {31'd0, bus.done}, 32'd1);
    check("latency_busy", {31'd0, bus.busy}, 32'd0);
    check_result("t1", 8'h1E, 1'b0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);

    issue(8'h00, 8'h01, 1'b0);
    wait_done("t2");
    check_result("t2", 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    issue(8'h80, 8'h01, 1'b0);
    wait_done("t3");
    check_result("t3", 8'h7F, 1'b0, 1'b1);
    @(negedge clk);

    // Equal operands with borrow-in, then hold through idle.
    issue(8'h10, 8'h10, 1'b1);
    wait_done("t4");
    check_result("t4", 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_idle_diff", {24'd0, bus.diff}, 32'hFF);
      check("hold_idle_done", {31'd0, bus.done}, 32'd0);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(8'h05, 8'h03, 1'b0);
    repeat (2) @(negedge clk);
    issue(8'hFF, 8'h00, 1'b0);
    wait_done("t5");
    check_result("t5", 8'h02, 1'b0, 1'b0);
    issue(8'h7F, 8'hFF, 1'b0);
    @(negedge clk);
    check("b2b_done_low", {31'd0, bus.done}, 32'd0);
    check("b2b_busy_high", {31'd0, bus.busy}, 32'd1);
    check("b2b_hold_diff", {24'd0, bus.diff}, 32'h02);
    wait_done("t6");
    check_result("t6", 8'h80, 1'b1, 1'b1);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    issue(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check_result("arst", 8'h00, 1'b0, 1'b0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {31'd0, bus.busy}, 32'd0);
    issue(8'h03, 8'h01, 1'b0);
    wait_done("t7");
    check_result("t7", 8'h02, 1'b0, 1'b0);

    // Random sweep: both borrow-in values, mixed idle and back-to-back starts.
    for (int i = 0; i < 500; i++) begin
      for (int bw = 0; bw < 2; bw++) begin
        if ($urandom_range(0, 1) == 0) @(negedge clk);
        issue(W'($urandom), W'($urandom), bw[0]);
        wait_done("rand");
      end
    end
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial 8-bit subtractor computing diff = a − b − bw_in, one bit per clock, LSB first, with a rippling borrow flip-flop.
- Area-minimal sequential counterpart to the combinational ripple-carry adder in the ALU lab set: one full-subtractor cell plus shift registers instead of eight chained cells.
- Driven by a start/busy/done handshake from the lab controller FSM.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2); counter width = clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled each rising edge; accepted only when busy=0
- a  input  WIDTH  minuend; sampled on accepted start only
- b  input  WIDTH  subtrahend; sampled on accepted start only
- bw_in  input  1  borrow-in; sampled on accepted start only
- busy  output  1  high while the operation is in progress
- done  output  1  one-cycle pulse; results valid from this cycle onward
- diff  output  WIDTH  result a−b−bw_in mod 2^WIDTH
- bw_out  output  1  final borrow; 1 when a < b+bw_in (unsigned)
- overflow  output  1  signed (two's-complement) overflow of the subtraction

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state=IDLE; busy=0, done=0, diff=0, bw_out=0, overflow=0; shift registers, borrow FF and counter cleared. Reset asserted mid-operation aborts immediately. No partial result is ever presented. After release, the block waits for a new start.
- States: IDLE, RUN, DONE. Outputs busy=(state==RUN), done=(state==DONE).
- IDLE or DONE with start=1 at edge E0:
  - a→sa, b→sb, bw_in→br.
  - Store a[WIDTH-1] and b[WIDTH-1] for the overflow computation.
  - count=0; state→RUN.
- DONE with start=0: state→IDLE.
- RUN, each edge:
  - Per-bit logic: d = sa[0]^sb[0]^br; br' = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - sa and sb shift right. d shifts into the MSB of the internal result shift register. count increments.
  - At the edge where count reaches WIDTH−1 (edge E0+WIDTH), the final bit is processed and the following are registered:
    - diff ← completed result
    - bw_out ← br'
    - overflow ← (a_msb≠b_msb) & (diff_msb≠a_msb)
    - state→DONE
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after start is sampled. done is exactly 1 cycle wide. busy is high for exactly WIDTH cycles.
- diff, bw_out and overflow change only at the completion edge. They hold through IDLE and through the next RUN until that run completes. Intermediate bits are never visible on diff.
- start while busy=1: ignored, with no effect on the operation in flight. Operands are not re-sampled.
- start during the DONE cycle: accepted, giving back-to-back operation (done and busy never high together). The previous results stay on the outputs until the new completion edge.
- Operand inputs are don't-care outside the sampling edge.
- All arithmetic is modulo 2^WIDTH. bw_in=1 with a=b yields all-ones and bw_out=1.

Test Plan:
- Reset, then start with a=0x5A, b=0x3C, bw_in=0 → busy high 8 cycles; done pulses 8 cycles after start; diff=0x1E, bw_out=0, overflow=0.
- a=0x00, b=0x01, bw_in=0 → diff=0xFF, bw_out=1, overflow=0. Then a=0x80, b=0x01 → diff=0x7F, bw_out=0, overflow=1.
- a=0x10, b=0x10, bw_in=1 → diff=0xFF, bw_out=1, overflow=0. Check that diff holds 0xFF through the following idle cycles.
- Start a=0x05, b=0x03; pulse start with a=0xFF, b=0x00 at cycle 3 of busy → ignored; result is diff=0x02, bw_out=0. Then assert start during the done cycle with a=0x7F, b=0xFF → accepted; done is not re-asserted in the next cycle; diff=0x80, bw_out=1, overflow=1 after 8 more cycles.
- Start a=0xAA, b=0x55; drop rst_n asynchronously (mid-cycle) at cycle 4 → busy, done, diff, bw_out and overflow all 0 immediately. Release rst_n; a new start with a=0x03, b=0x01 gives diff=0x02 after 8 cycles.
- Random sweep of 1000 operands plus all bw_in values, checked against a reference model of {bw_out,diff} = {1'b0,a} − {1'b0,b} − bw_in.
